// File: rtl/nn_sequencer.sv
// Frame sequencer for a neural-network block: assembles a pixel frame, launches
// the network, waits (bounded) for its result and holds that result for the consumer.
module nn_sequencer #(
   parameter int dataWidth     = 16,
   parameter int numInputs     = 784,
   parameter int timeoutCycles = 4096
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           abort,
   input  logic [dataWidth-1:0]           pixIn,
   input  logic                           pixValid,
   output logic                           pixReady,
   output logic [dataWidth*numInputs-1:0] NNin,
   output logic                           NNvalid,
   input  logic [3:0]                     maxIndex,
   input  logic [dataWidth-1:0]           maxValue,
   input  logic                           maxValid,
   output logic [3:0]                     resIndex,
   output logic [dataWidth-1:0]           resValue,
   output logic                           resError,
   output logic                           resValid,
   input  logic                           resReady,
   output logic                           busy,
   output logic [15:0]                    frameCount
);

   // state  | meaning
   // S_LOAD | accepting pixels into the frame buffer
   // S_FIRE | one-cycle launch strobe to the network
   // S_WAIT | waiting for the network result, bounded by the timeout counter
   // S_DONE | result held until the consumer takes it

   localparam int KW = (numInputs > 1) ? $clog2(numInputs) : 1;
   localparam int TW = (timeoutCycles > 1) ? $clog2(timeoutCycles) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(numInputs - 1);
   localparam logic [TW-1:0] T_LAST = TW'(timeoutCycles - 1);

   typedef enum logic [1:0] {S_LOAD, S_FIRE, S_WAIT, S_DONE} state_t;

   state_t                         r_state;
   state_t                         w_next;
   logic [KW-1:0]                  r_k;
   logic [TW-1:0]                  r_tmo;
   logic [dataWidth*numInputs-1:0] r_nnin;
   logic [3:0]                     r_res_idx;
   logic [dataWidth-1:0]           r_res_val;
   logic                           r_res_err;
   logic [15:0]                    r_frame_cnt;
   logic                           w_accept;
   logic                           w_last;
   logic                           w_tmo_hit;

   assign w_accept  = (r_state == S_LOAD) && pixValid;
   assign w_last    = (r_k == K_LAST);
   assign w_tmo_hit = (r_tmo == T_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_LOAD;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      if (abort) begin
         w_next = S_LOAD;
      end else begin
         case (r_state)
            S_LOAD: if (w_accept && w_last) w_next = S_FIRE;
            S_FIRE: w_next = S_WAIT;
            S_WAIT: if (maxValid || w_tmo_hit) w_next = S_DONE;
            S_DONE: if (resReady) w_next = S_LOAD;
            default: w_next = S_LOAD;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_k         <= '0;
         r_tmo       <= '0;
         r_nnin      <= '0;
         r_res_idx   <= '0;
         r_res_val   <= '0;
         r_res_err   <= 1'b0;
         r_frame_cnt <= '0;
      end else if (abort) begin
         r_k   <= '0;
         r_tmo <= '0;
      end else begin
         case (r_state)
            S_LOAD: begin
               if (w_accept) begin
                  r_nnin[r_k*dataWidth +: dataWidth] <= pixIn;
                  r_k <= w_last ? '0 : r_k + 1'b1;
               end
            end
            S_FIRE: r_tmo <= '0;
            S_WAIT: begin
               // a result arriving on the final timeout cycle still counts
               if (maxValid) begin
                  r_res_idx <= maxIndex;
                  r_res_val <= maxValue;
                  r_res_err <= 1'b0;
               end else if (w_tmo_hit) begin
                  r_res_idx <= 4'hF;
                  r_res_val <= '0;
                  r_res_err <= 1'b1;
               end else begin
                  r_tmo <= r_tmo + 1'b1;
               end
            end
            S_DONE: if (resReady) r_frame_cnt <= r_frame_cnt + 16'd1;
            default: ;
         endcase
      end
   end

   assign pixReady   = (r_state == S_LOAD);
   assign NNvalid    = (r_state == S_FIRE);
   assign resValid   = (r_state == S_DONE);
   assign busy       = (r_state == S_FIRE) || (r_state == S_WAIT);
   assign NNin       = r_nnin;
   assign resIndex   = r_res_idx;
   assign resValue   = r_res_val;
   assign resError   = r_res_err;
   assign frameCount = r_frame_cnt;

endmodule

// File: tb/tb_nn_sequencer.sv
// Self-checking bench for nn_sequencer: random frames and network responses
// compared against a transaction-level model of frame contents, result and count.
module tb_nn_sequencer;
   localparam int DW = 16;
   localparam int NI = 784;
   localparam int TO = 16;

   logic           clk = 1'b0;
   logic           reset, abort, pixValid, maxValid, resReady;
   logic [DW-1:0]  pixIn, maxValue, resValue;
   logic [3:0]     maxIndex, resIndex;
   logic [DW*NI-1:0] NNin;
   logic           pixReady, NNvalid, resError, resValid, busy;
   logic [15:0]    frameCount;

   int             n_tests = 0;
   int             n_fail  = 0;
   logic [DW-1:0]  exp_frame [NI];
   logic [15:0]    exp_fc;

   nn_sequencer #(.dataWidth(DW), .numInputs(NI), .timeoutCycles(TO)) dut (
      .clk(clk), .reset(reset), .abort(abort),
      .pixIn(pixIn), .pixValid(pixValid), .pixReady(pixReady),
      .NNin(NNin), .NNvalid(NNvalid),
      .maxIndex(maxIndex), .maxValue(maxValue), .maxValid(maxValid),
      .resIndex(resIndex), .resValue(resValue), .resError(resError),
      .resValid(resValid), .resReady(resReady),
      .busy(busy), .frameCount(frameCount)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic check_nnin(input string tag);
      for (int k = 0; k < NI; k++)
         chk($sformatf("%s[%0d]", tag, k), 32'(NNin[k*DW +: DW]), 32'(exp_frame[k]));
   endtask

   // called at a negedge; returns at the negedge after the last pixel was driven
   task automatic send_pixels(input int n, input bit seq, input bit gaps);
      for (int i = 0; i < n; i++) begin
         int g;
         g = (gaps && $urandom_range(3) == 0) ? int'($urandom_range(2, 1)) : 0;
         for (int j = 0; j < g; j++) begin
            pixValid = 1'b0;
            pixIn    = DW'($urandom);
            @(negedge clk);
         end
         exp_frame[i] = seq ? DW'(i) : DW'($urandom);
         pixValid = 1'b1;
         pixIn    = exp_frame[i];
         maxValid = 1'($urandom_range(1));
         maxIndex = 4'($urandom);
         maxValue = DW'($urandom);
         @(negedge clk);
      end
      pixValid = 1'b0;
      maxValid = 1'b0;
   endtask

   task automatic check_fire();
      chk("fire_nnvalid", 32'(NNvalid), 32'd1);
      chk("fire_busy", 32'(busy), 32'd1);
      chk("fire_pixready", 32'(pixReady), 32'd0);
      chk("fire_resvalid", 32'(resValid), 32'd0);
      check_nnin("fire_nnin");
   endtask

   task automatic do_reset(input string tag);
      reset = 1'b1;
      #1;
      chk({tag, "_resvalid"}, 32'(resValid), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_nnvalid"}, 32'(NNvalid), 32'd0);
      chk({tag, "_fc"}, 32'(frameCount), 32'd0);
      chk({tag, "_residx"}, 32'(resIndex), 32'd0);
      chk({tag, "_resval"}, 32'(resValue), 32'd0);
      chk({tag, "_reserr"}, 32'(resError), 32'd0);
      chk({tag, "_nnin_zero"}, 32'(NNin == '0), 32'd1);
      abort = 1'b0; pixValid = 1'b0; maxValid = 1'b0; resReady = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk({tag, "_pixready"}, 32'(pixReady), 32'd1);
      exp_fc = 16'd0;
      for (int k = 0; k < NI; k++) exp_frame[k] = '0;
   endtask

   // starts at the FIRE negedge; mode 0 consume, 1 abort in DONE, 2 reset in DONE
   task automatic respond(input bit hit, input int d, input logic [3:0] idx,
                          input logic [DW-1:0] val, input int hold, input int mode);
      logic [3:0]    e_idx;
      logic [DW-1:0] e_val;
      logic          e_err;
      int            last;
      last = hit ? d : TO - 1;
      maxValid = 1'b1;
      maxIndex = 4'($urandom);
      maxValue = DW'($urandom);
      for (int j = 0; j <= last; j++) begin
         @(negedge clk);
         chk("wait_busy", 32'(busy), 32'd1);
         chk("wait_resvalid", 32'(resValid), 32'd0);
         chk("wait_pixready", 32'(pixReady), 32'd0);
         if (j == 0) chk("nnvalid_one_cycle", 32'(NNvalid), 32'd0);
         pixValid = 1'($urandom_range(1));
         pixIn    = DW'($urandom);
         maxValid = hit && (j == d);
         maxIndex = (hit && j == d) ? idx : 4'($urandom);
         maxValue = (hit && j == d) ? val : DW'($urandom);
      end
      @(negedge clk);
      pixValid = 1'b0;
      e_idx = hit ? idx : 4'hF;
      e_val = hit ? val : '0;
      e_err = !hit;
      for (int h = 0; h <= hold; h++) begin
         chk("done_resvalid", 32'(resValid), 32'd1);
         chk("done_residx", 32'(resIndex), 32'(e_idx));
         chk("done_resval", 32'(resValue), 32'(e_val));
         chk("done_reserr", 32'(resError), 32'(e_err));
         chk("done_busy", 32'(busy), 32'd0);
         chk("done_pixready", 32'(pixReady), 32'd0);
         maxValid = 1'($urandom_range(1));
         maxIndex = 4'($urandom);
         maxValue = DW'($urandom);
         if (h < hold) @(negedge clk);
      end
      maxValid = 1'b0;
      check_nnin("held_nnin");
      if (mode == 2) begin
         do_reset("rst_done");
      end else begin
         resReady = 1'b1;
         abort    = (mode == 1);
         @(negedge clk);
         resReady = 1'b0;
         abort    = 1'b0;
         if (mode == 0) exp_fc = exp_fc + 16'd1;
         chk("consume_fc", 32'(frameCount), 32'(exp_fc));
         chk("consume_pixready", 32'(pixReady), 32'd1);
         chk("consume_resvalid", 32'(resValid), 32'd0);
      end
   endtask

   initial begin
      reset = 1'b1; abort = 1'b0; pixValid = 1'b0; maxValid = 1'b0; resReady = 1'b0;
      pixIn = '0; maxIndex = '0; maxValue = '0;
      exp_fc = 16'd0;
      for (int k = 0; k < NI; k++) exp_frame[k] = '0;
      repeat (2) @(negedge clk);
      chk("rst_resvalid", 32'(resValid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_fc", 32'(frameCount), 32'd0);
      chk("rst_nnin_zero", 32'(NNin == '0), 32'd1);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_pixready", 32'(pixReady), 32'd1);

      // sequential frame, immediate result, held 5 cycles
      send_pixels(NI, 1'b1, 1'b0);
      check_fire();
      respond(1'b1, 0, 4'd7, 16'h0123, 5, 0);

      // network never answers: timeout result
      send_pixels(NI, 1'b0, 1'b1);
      check_fire();
      respond(1'b0, 0, 4'd0, '0, 2, 0);

      // result on the very last timeout cycle wins
      send_pixels(NI, 1'b0, 1'b1);
      check_fire();
      respond(1'b1, TO - 1, 4'd3, 16'hBEEF, 1, 0);

      // abort mid-load, then a full frame must start from pixel 0
      send_pixels(300, 1'b0, 1'b1);
      abort = 1'b1; pixValid = 1'b1; pixIn = DW'($urandom);
      @(negedge clk);
      abort = 1'b0; pixValid = 1'b0;
      chk("abort_load_pixready", 32'(pixReady), 32'd1);
      chk("abort_load_busy", 32'(busy), 32'd0);
      send_pixels(NI, 1'b0, 1'b1);
      check_fire();
      respond(1'b1, 4, 4'd9, 16'h5A5A, 0, 0);

      // abort in WAIT
      send_pixels(NI, 1'b0, 1'b0);
      check_fire();
      repeat (3) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_wait_pixready", 32'(pixReady), 32'd1);
      chk("abort_wait_busy", 32'(busy), 32'd0);
      chk("abort_wait_resvalid", 32'(resValid), 32'd0);
      chk("abort_wait_fc", 32'(frameCount), 32'(exp_fc));

      // abort in DONE beats resReady
      send_pixels(NI, 1'b0, 1'b1);
      check_fire();
      respond(1'b1, 2, 4'd1, 16'h0042, 1, 1);

      // random frames and responses
      for (int f = 0; f < 3; f++) begin
         bit hit;
         hit = 1'($urandom_range(1));
         send_pixels(NI, 1'b0, 1'b1);
         check_fire();
         respond(hit, int'($urandom_range(TO - 1)), 4'($urandom), DW'($urandom),
                 int'($urandom_range(4)), 0);
      end

      // reset mid-WAIT
      send_pixels(NI, 1'b0, 1'b0);
      check_fire();
      repeat (4) @(negedge clk);
      do_reset("rst_wait");

      // reset mid-DONE
      send_pixels(NI, 1'b0, 1'b1);
      check_fire();
      respond(1'b1, 1, 4'd5, 16'h7777, 2, 2);

      // frame counter wraps from FFFF to 0
      force dut.r_frame_cnt = 16'hFFFF;
      #1;
      release dut.r_frame_cnt;
      exp_fc = 16'hFFFF;
      send_pixels(NI, 1'b0, 1'b0);
      check_fire();
      respond(1'b1, 0, 4'd2, 16'h1234, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/nn_sequencer.md
NN_SEQUENCER -- requirements
Module: nn_sequencer

Interface
REQ-001 SHALL have parameter dataWidth, default 16, width of one pixel and of maxValue.
REQ-002 SHALL have parameter numInputs, default 784, pixels per frame.
REQ-003 SHALL have parameter timeoutCycles, default 4096, maximum WAIT cycles before error.
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port abort  input  1  synchronous frame abort.
REQ-007 SHALL have port pixIn  input  dataWidth  streamed pixel.
REQ-008 SHALL have port pixValid  input  1  pixIn valid.
REQ-009 SHALL have port pixReady  output  1  sequencer accepts pixel.
REQ-010 SHALL have port NNin  output  dataWidth*numInputs  assembled frame to network.
REQ-011 SHALL have port NNvalid  output  1  one-cycle frame launch strobe.
REQ-012 SHALL have port maxIndex  input  4  network winning class.
REQ-013 SHALL have port maxValue  input  dataWidth  network winning score.
REQ-014 SHALL have port maxValid  input  1  network result strobe.
REQ-015 SHALL have port resIndex  output  4  captured class, 4'hF on error.
REQ-016 SHALL have port resValue  output  dataWidth  captured score, 0 on error.
REQ-017 SHALL have port resError  output  1  result is a timeout.
REQ-018 SHALL have port resValid  output  1  result held for consumer.
REQ-019 SHALL have port resReady  input  1  consumer takes result.
REQ-020 SHALL have port busy  output  1  high in FIRE or WAIT.
REQ-021 SHALL have port frameCount  output  16  results consumed, wraps 16'hFFFF -> 0.

Function
REQ-022 SHALL implement states LOAD, FIRE, WAIT, DONE; encoding free.
REQ-023 LOAD: pixReady=1; on pixValid&&pixReady, SHALL write pixIn to NNin[k*dataWidth +: dataWidth], k = pixel counter, then increment k.
REQ-024 Accepting pixel k=numInputs-1 SHALL reset k to 0 and enter FIRE next cycle; pixValid low SHALL stall without changing k.
REQ-025 FIRE: NNvalid=1 for exactly one cycle, NNin stable, next state WAIT; NNin SHALL stay unchanged through FIRE, WAIT, DONE.
REQ-026 WAIT: timeout counter SHALL start at 0 on entry and increment each cycle without maxValid.
REQ-027 WAIT with maxValid=1 SHALL capture maxIndex/maxValue into resIndex/resValue, resError=0, go DONE.
REQ-028 WAIT with counter reaching timeoutCycles-1 and maxValid=0 SHALL set resIndex=4'hF, resValue=0, resError=1, go DONE; maxValid in that same cycle wins.
REQ-029 DONE: resValid=1, res* stable until resValid&&resReady; that cycle SHALL increment frameCount and return to LOAD.
REQ-030 maxValid outside WAIT SHALL be ignored; pixValid outside LOAD SHALL be ignored (pixReady=0).
REQ-031 abort=1 in any state SHALL next cycle force LOAD, k=0, timeout counter 0, resValid=0, NNvalid=0; frameCount unchanged; abort has priority over all other events, including pixel accept and resReady.
REQ-032 Latency: last pixel accept cycle N -> NNvalid at N+1 -> earliest resValid at N+3 (maxValid at N+2).
REQ-033 pixReady, NNvalid, resValid, busy SHALL be registered-state decodes, no combinational path from inputs.

Reset
REQ-034 reset=1 SHALL asynchronously force LOAD, k=0, timeout counter 0, NNin=0, NNvalid=0, resIndex=0, resValue=0, resError=0, resValid=0, busy=0, frameCount=0; pixReady=1 after release.

Verification
REQ-035 Stream 784 pixels value=k, pixValid continuous -> NNvalid one cycle after last, NNin slice k = k.
REQ-036 In WAIT drive maxValid with maxIndex=7, maxValue=16'h0123 -> resValid=1, resIndex=7, resValue=16'h0123, resError=0; hold resReady=0 5 cycles -> outputs stable; resReady=1 -> frameCount=1, pixReady=1 next cycle.
REQ-037 Never assert maxValid, timeoutCycles=16 -> resValid 16 cycles after WAIT entry, resIndex=4'hF, resValue=0, resError=1.
REQ-038 Assert abort after 300 pixels -> next cycle LOAD, k=0; next full frame of 784 pixels fires NNvalid correctly; stray maxValid in LOAD no effect.
REQ-039 Assert reset mid-WAIT and mid-DONE -> all outputs to reset values immediately, frameCount=0.
REQ-040 Preload frameCount to 16'hFFFF via 65535 quick frames (short numInputs) -> next consumed result wraps to 0.
